// File: rtl/ai_core_pkg.sv
// Shared types and constants for the arithmetic core blocks.
package ai_core_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Fill bit replicated across the quotient when the divisor is zero.
  localparam logic DIV_ZERO_FILL_BIT = 1'b1;

endpackage

// File: rtl/adder_n.sv
// Plain SIZE-bit combinational adder; carry out is dropped.
module adder_n #(
  parameter int unsigned SIZE = 8
) (
  input  logic [SIZE-1:0] a_i,
  input  logic [SIZE-1:0] b_i,
  output logic [SIZE-1:0] sum_c
);

  assign sum_c = a_i + b_i;

endmodule

// File: rtl/divider_n.sv
// Iterative unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on the operand and result sides.
module divider_n
  import ai_core_pkg::*;
#(
  parameter int unsigned SIZE = 18
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [SIZE-1:0] dividend_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [SIZE-1:0] quotient_o,
  output logic [SIZE-1:0] remainder_o,
  output logic            div_by_zero_o
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned RW = SIZE + 1;

  div_state_e state_q, state_d;

  // Partial remainder stays below the divisor, so its top bit is always zero
  // and only SIZE bits are stored.
  logic [SIZE-1:0] rem_q;
  logic [SIZE-1:0] quo_q;
  logic [RW-1:0]   neg_div_q;
  logic [CW-1:0]   cnt_q;
  logic            last_q;

  logic [RW-1:0]   shifted_c;
  logic [RW-1:0]   trial_c;
  logic            load_c;
  logic            zero_c;
  logic            step_c;
  logic            finish_c;

  assign shifted_c = {rem_q, quo_q[SIZE-1]};

  adder_n #(
    .SIZE (RW)
  ) u_trial (
    .a_i   (shifted_c),
    .b_i   (neg_div_q),
    .sum_c (trial_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    zero_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (in_valid_i && in_ready_o) begin
          if (divisor_i == '0) begin
            zero_c  = 1'b1;
            state_d = DIV_DONE;
          end else begin
            load_c  = 1'b1;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        // One settle cycle after the final iteration before publishing.
        if (last_q) begin
          finish_c = 1'b1;
          state_d  = DIV_DONE;
        end else begin
          step_c = 1'b1;
        end
      end
      DIV_DONE: begin
        if (out_ready_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // State register with registered handshake flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= DIV_IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_o  <= (state_d == DIV_IDLE);
      out_valid_o <= (state_d == DIV_DONE);
    end
  end

  // Working registers and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q         <= '0;
      quo_q         <= '0;
      neg_div_q     <= '0;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      if (load_c) begin
        rem_q     <= '0;
        quo_q     <= dividend_i;
        neg_div_q <= RW'(0) - {1'b0, divisor_i};
        cnt_q     <= '0;
        last_q    <= 1'b0;
      end else if (step_c) begin
        // Negative trial result means the divisor did not fit: restore.
        rem_q  <= trial_c[SIZE] ? shifted_c[SIZE-1:0] : trial_c[SIZE-1:0];
        quo_q  <= {quo_q[SIZE-2:0], ~trial_c[SIZE]};
        cnt_q  <= cnt_q + CW'(1);
        last_q <= (cnt_q == CW'(SIZE - 1));
      end

      if (zero_c) begin
        quotient_o    <= {SIZE{DIV_ZERO_FILL_BIT}};
        remainder_o   <= dividend_i;
        div_by_zero_o <= 1'b1;
      end else if (finish_c) begin
        quotient_o    <= quo_q;
        remainder_o   <= rem_q;
        div_by_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_n.sv
// Self-checking bench for divider_n: directed cases plus a randomized
// scoreboard run against a plain / and % reference.
module tb_divider_n;

  localparam int unsigned SIZE  = 18;
  localparam int unsigned NRAND = 1500;
  localparam logic [SIZE-1:0] ONES = '1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [SIZE-1:0] dividend_i = '0;
  logic [SIZE-1:0] divisor_i = '0;
  logic            out_valid_o;
  logic            out_ready_i = 1'b0;
  logic [SIZE-1:0] quotient_o;
  logic [SIZE-1:0] remainder_o;
  logic            div_by_zero_o;

  int n_checks = 0;
  int n_fail   = 0;

  divider_n #(.SIZE(SIZE)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [SIZE-1:0] ref_q(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    return (b == '0) ? ONES : a / b;
  endfunction

  function automatic logic [SIZE-1:0] ref_r(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  function automatic logic [SIZE-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return ONES;
      2:       return SIZE'($urandom_range(1, 15));
      default: return SIZE'($urandom);
    endcase
  endfunction

  // Present operands, wait for ready, and stop just after the accept edge.
  task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int guard = 0;
    dividend_i = a;
    divisor_i  = b;
    in_valid_i = 1'b1;
    while (!in_ready_o && guard < 50) begin
      tick();
      guard++;
    end
    chk("accept_ready", 32'(in_ready_o), 32'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  // Latency counted in edges after the accept edge.
  task automatic await_result(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input string tag);
    int lat = 0;
    while (!out_valid_o && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), (b == '0) ? 32'd0 : 32'(SIZE + 1));
    chk({tag, "_q"},   32'(quotient_o),    32'(ref_q(a, b)));
    chk({tag, "_r"},   32'(remainder_o),   32'(ref_r(a, b)));
    chk({tag, "_dbz"}, 32'(div_by_zero_o), (b == '0) ? 32'd1 : 32'd0);
  endtask

  task automatic release_result();
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("release_valid", 32'(out_valid_o), 32'd0);
    chk("release_ready", 32'(in_ready_o), 32'd1);
  endtask

  logic [SIZE-1:0] ext_a [6] = '{18'd100, 18'd5, 18'h3FFFF, 18'h3FFFF, 18'd5, 18'd0};
  logic [SIZE-1:0] ext_b [6] = '{18'd7,   18'd0, 18'd1,     18'h3FFFF, 18'd9, 18'd3};

  logic [SIZE-1:0] exp_q [$];
  logic [SIZE-1:0] exp_r [$];
  logic            exp_z [$];

  initial begin
    int accepted = 0;
    int delivered = 0;
    int cyc = 0;

    // Reset state
    #12;
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_q", 32'(quotient_o), 32'd0);
    chk("rst_r", 32'(remainder_o), 32'd0);
    chk("rst_dbz", 32'(div_by_zero_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // Directed and extreme operands
    for (int i = 0; i < 6; i++) begin
      launch(ext_a[i], ext_b[i]);
      await_result(ext_a[i], ext_b[i], $sformatf("ext%0d", i));
      release_result();
    end

    // Backpressure in DONE with a new operation waiting
    launch(18'd100, 18'd7);
    await_result(18'd100, 18'd7, "bp");
    dividend_i = 18'd77;
    divisor_i  = 18'd5;
    in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid_o), 32'd1);
      chk("bp_hold_ready", 32'(in_ready_o), 32'd0);
      chk("bp_hold_q", 32'(quotient_o), 32'd14);
      chk("bp_hold_r", 32'(remainder_o), 32'd2);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("bp_idle_ready", 32'(in_ready_o), 32'd1);
    chk("bp_idle_valid", 32'(out_valid_o), 32'd0);
    tick();
    in_valid_i = 1'b0;
    await_result(18'd77, 18'd5, "bp_next");
    release_result();

    // Reset during BUSY at iteration 9
    launch(18'd1000, 18'd3);
    repeat (9) tick();
    #2 rst_ni = 1'b0;
    #1;
    chk("rstbusy_valid", 32'(out_valid_o), 32'd0);
    chk("rstbusy_ready", 32'(in_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    launch(18'd1000, 18'd3);
    await_result(18'd1000, 18'd3, "after_rst");
    chk("after_rst_q333", 32'(quotient_o), 32'd333);

    // Reset while a result is waiting in DONE
    chk("rstdone_pre_valid", 32'(out_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstdone_valid", 32'(out_valid_o), 32'd0);
    chk("rstdone_ready", 32'(in_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    tick();

    // Randomized regression with stalls on both sides
    while ((accepted < NRAND || exp_q.size() != 0) && cyc < 60000) begin
      in_valid_i  = (accepted < NRAND) && ($urandom_range(0, 3) != 0);
      dividend_i  = pick();
      divisor_i   = pick();
      out_ready_i = (accepted >= NRAND) || ($urandom_range(0, 2) != 0);
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("rand_spurious", 32'd1, 32'd0);
        end else begin
          chk("rand_q",   32'(quotient_o),    32'(exp_q.pop_front()));
          chk("rand_r",   32'(remainder_o),   32'(exp_r.pop_front()));
          chk("rand_dbz", 32'(div_by_zero_o), 32'(exp_z.pop_front()));
        end
        delivered++;
      end
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(ref_q(dividend_i, divisor_i));
        exp_r.push_back(ref_r(dividend_i, divisor_i));
        exp_z.push_back(divisor_i == '0);
        accepted++;
      end
      tick();
      cyc++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_count", 32'(delivered), 32'(NRAND));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
